// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter: FSM states, command
// bundle and the default starvation limit.
package mem_arbiter_pkg;

  localparam int STARVE_LIMIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_DM = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access, one
// transaction in flight at a time; data wins ties unless fetch is starving.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output arb_state_t  state_o,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] starve_cnt_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             if_win, dm_win;
  mem_cmd_t         cmd;

  // Handshake: a requester holds req and payload stable until it sees gnt;
  // a command is accepted only in a cycle where mem_req and mem_ready are both
  // high, and nothing unaccepted is ever latched here.
  always_comb begin
    if_win       = 1'b0;
    dm_win       = 1'b0;
    cmd          = '0;
    state_d      = state_q;
    cnt_d        = cnt_q;
    if_gnt       = 1'b0;
    dm_gnt       = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    dm_rvalid    = 1'b0;
    dm_rdata     = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = '0;
    state_o      = IDLE;
    starve_cnt_o = '0;

    if (state_q == IDLE) begin
      dm_win = dm_req && !(if_req && (cnt_q == LIMIT));
      if_win = if_req && !dm_win;
      if (dm_win) begin
        cmd = '{we: dm_we, addr: dm_addr, wdata: dm_wdata, be: dm_be};
      end else if (if_win) begin
        cmd = '{we: 1'b0, addr: if_addr, wdata: 32'h0, be: 4'hF};
      end
      if ((dm_win || if_win) && mem_ready) begin
        state_d = dm_win ? WAIT_DM : WAIT_IF;
      end
      if (if_win && mem_ready) begin
        cnt_d = '0;
      end else if (dm_win && mem_ready && if_req) begin
        if (cnt_q != LIMIT) cnt_d = cnt_q + CNT_W'(1);
      end else if (!if_req) begin
        cnt_d = '0;
      end
    end else if (mem_rvalid) begin
      state_d = IDLE;
    end

    // Every output is held at zero while reset is asserted.
    if (!rst) begin
      mem_req      = if_win || dm_win;
      mem_we       = cmd.we;
      mem_addr     = cmd.addr;
      mem_wdata    = cmd.wdata;
      mem_be       = cmd.be;
      if_gnt       = if_win && mem_ready;
      dm_gnt       = dm_win && mem_ready;
      if_rvalid    = (state_q == WAIT_IF) && mem_rvalid;
      dm_rvalid    = (state_q == WAIT_DM) && mem_rvalid;
      if_rdata     = if_rvalid ? mem_rdata : 32'h0;
      dm_rdata     = dm_rvalid ? mem_rdata : 32'h0;
      state_o      = state_q;
      starve_cnt_o = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single-cycle arbitration vectors
// plus hand-written multi-cycle sequences (response, starvation, stall, reset).
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk, rst;
  logic        if_req, dm_req, dm_we, mem_ready, mem_rvalid;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  arb_state_t  state_o;
  logic [2:0]  starve_cnt_o;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .state_o(state_o), .starve_cnt_o(starve_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        mem_ready;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_if_gnt;
    logic        e_dm_gnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0;
    dm_wdata = 0; dm_be = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  // Reset for one edge; returns at a falling edge with reset released.
  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    vecs[0] = '{"no_req",       0, 32'h0,   0, 0, 32'h0,   32'h0,        4'h0, 1,
                0, 0, 32'h0,   32'h0,        4'h0, 0, 0};
    vecs[1] = '{"lone_if",      1, 32'h40,  0, 0, 32'h0,   32'h0,        4'h0, 1,
                1, 0, 32'h40,  32'h0,        4'hF, 1, 0};
    vecs[2] = '{"lone_if_stall",1, 32'h40,  0, 0, 32'h0,   32'h0,        4'h0, 0,
                1, 0, 32'h40,  32'h0,        4'hF, 0, 0};
    vecs[3] = '{"lone_dm_wr",   0, 32'h0,   1, 1, 32'h200, 32'hDEADBEEF, 4'hF, 1,
                1, 1, 32'h200, 32'hDEADBEEF, 4'hF, 0, 1};
    vecs[4] = '{"contend_wr",   1, 32'h80,  1, 1, 32'h100, 32'h00001234, 4'h3, 1,
                1, 1, 32'h100, 32'h00001234, 4'h3, 0, 1};
    vecs[5] = '{"dm_rd_stall",  0, 32'h0,   1, 0, 32'h300, 32'h0000AAAA, 4'hF, 0,
                1, 0, 32'h300, 32'h0000AAAA, 4'hF, 0, 0};
    vecs[6] = '{"contend_stall",1, 32'h84,  1, 0, 32'h304, 32'h0,        4'hC, 0,
                1, 0, 32'h304, 32'h0,        4'hC, 0, 0};

    rst = 1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    // Outputs must be zero under reset even with live requests and responses.
    if_req = 1; dm_req = 1; dm_addr = 32'h55; mem_ready = 1; mem_rvalid = 1;
    mem_rdata = 32'h1234;
    #1;
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_gnts", {30'h0, if_gnt, dm_gnt}, 32'h0);
    check("rst_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 0;
    clear_inputs();
    #1;
    check("reset_state", {30'h0, state_o}, {30'h0, IDLE});
    check("reset_cnt", {29'h0, starve_cnt_o}, 32'h0);

    // Table vectors, each from a fresh reset so starvation history is empty.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
      dm_req = vecs[i].dm_req; dm_we = vecs[i].dm_we; dm_addr = vecs[i].dm_addr;
      dm_wdata = vecs[i].dm_wdata; dm_be = vecs[i].dm_be;
      mem_ready = vecs[i].mem_ready;
      #1;
      check({vecs[i].name, ".mem_req"}, {31'h0, mem_req}, {31'h0, vecs[i].e_req});
      check({vecs[i].name, ".mem_we"}, {31'h0, mem_we}, {31'h0, vecs[i].e_we});
      check({vecs[i].name, ".mem_addr"}, mem_addr, vecs[i].e_addr);
      check({vecs[i].name, ".mem_wdata"}, mem_wdata, vecs[i].e_wdata);
      check({vecs[i].name, ".mem_be"}, {28'h0, mem_be}, {28'h0, vecs[i].e_be});
      check({vecs[i].name, ".if_gnt"}, {31'h0, if_gnt}, {31'h0, vecs[i].e_if_gnt});
      check({vecs[i].name, ".dm_gnt"}, {31'h0, dm_gnt}, {31'h0, vecs[i].e_dm_gnt});
      @(negedge clk);
    end

    // Lone fetch with response the following cycle.
    do_reset();
    if_req = 1; if_addr = 32'h40; mem_ready = 1;
    #1;
    check("fetch.gnt", {31'h0, if_gnt}, 32'h1);
    @(negedge clk);
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'h00A00093;
    #1;
    check("fetch.state", {30'h0, state_o}, {30'h0, WAIT_IF});
    check("fetch.wait_no_req", {31'h0, mem_req}, 32'h0);
    check("fetch.rvalid", {31'h0, if_rvalid}, 32'h1);
    check("fetch.rdata", if_rdata, 32'h00A00093);
    check("fetch.dm_rvalid", {31'h0, dm_rvalid}, 32'h0);
    check("fetch.dm_rdata", dm_rdata, 32'h0);
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    check("fetch.back_idle", {30'h0, state_o}, {30'h0, IDLE});

    // Starvation: both requesting, response one cycle after every grant.
    do_reset();
    if_req = 1; if_addr = 32'h44; dm_req = 1; dm_addr = 32'h400; dm_be = 4'hF;
    mem_ready = 1;
    for (int k = 0; k < 10; k++) begin
      logic exp_dm;
      exp_dm = ((k % 5) != 4);
      mem_rvalid = 0;
      #1;
      check($sformatf("starve[%0d].dm_gnt", k), {31'h0, dm_gnt}, {31'h0, exp_dm});
      check($sformatf("starve[%0d].if_gnt", k), {31'h0, if_gnt}, {31'h0, !exp_dm});
      @(negedge clk);
      mem_rvalid = 1; mem_rdata = 32'h100 + k;
      #1;
      check($sformatf("starve[%0d].gnt_in_wait", k), {30'h0, if_gnt, dm_gnt}, 32'h0);
      check($sformatf("starve[%0d].dm_rvalid", k), {31'h0, dm_rvalid}, {31'h0, exp_dm});
      check($sformatf("starve[%0d].if_rvalid", k), {31'h0, if_rvalid}, {31'h0, !exp_dm});
      @(negedge clk);
    end

    // Backpressure: three stalled cycles, then grant when ready rises.
    do_reset();
    dm_req = 1; dm_we = 0; dm_addr = 32'h500; dm_be = 4'hF; mem_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall[%0d].mem_req", c), {31'h0, mem_req}, 32'h1);
      check($sformatf("stall[%0d].gnt", c), {30'h0, if_gnt, dm_gnt}, 32'h0);
      check($sformatf("stall[%0d].state", c), {30'h0, state_o}, {30'h0, IDLE});
      @(negedge clk);
    end
    mem_ready = 1;
    #1;
    check("stall.dm_gnt", {31'h0, dm_gnt}, 32'h1);
    @(negedge clk);
    dm_req = 0; mem_rdata = 32'hCAFEF00D;
    #1;
    check("stall.wait_rvalid", {31'h0, dm_rvalid}, 32'h0);
    check("stall.wait_rdata", dm_rdata, 32'h0);
    @(negedge clk);
    mem_rvalid = 1;
    #1;
    check("stall.resp_rdata", dm_rdata, 32'hCAFEF00D);
    @(negedge clk);
    mem_rvalid = 0;

    // Reset while in WAIT_DM abandons the outstanding response.
    do_reset();
    if_req = 1; dm_req = 1; dm_we = 1; dm_addr = 32'h600; dm_be = 4'h1;
    mem_ready = 1;
    #1;
    check("rstwait.dm_gnt", {31'h0, dm_gnt}, 32'h1);
    @(negedge clk);
    #1;
    check("rstwait.state", {30'h0, state_o}, {30'h0, WAIT_DM});
    check("rstwait.cnt", {29'h0, starve_cnt_o}, 32'h1);
    rst = 1; mem_rvalid = 1; mem_rdata = 32'h77;
    #1;
    check("rstwait.in_rst_rvalid", {31'h0, dm_rvalid}, 32'h0);
    @(negedge clk);
    rst = 0; if_req = 0; dm_req = 0;
    #1;
    check("rstwait.after_rvalid", {31'h0, dm_rvalid}, 32'h0);
    check("rstwait.after_state", {30'h0, state_o}, {30'h0, IDLE});
    check("rstwait.after_cnt", {29'h0, starve_cnt_o}, 32'h0);
    @(negedge clk);

    // Stray response in IDLE with no requests.
    do_reset();
    mem_rvalid = 1; mem_rdata = 32'h9999;
    #1;
    check("stray.rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
    check("stray.rdata", if_rdata | dm_rdata, 32'h0);
    @(negedge clk);
    #1;
    check("stray.state", {30'h0, state_o}, {30'h0, IDLE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
